regfile_ctx_sequencer: RTL
==========================

Name: regfile_ctx_sequencer

Overview:
Initiator-side sequencer for the 32x64 register file's two read ports and one write port. On command it dumps all registers as a ready/valid word stream (context save), or refills all registers from an incoming stream (context restore). It sits between the register file and the context-switch or debug logic, and is the only agent driving the register file's ports while busy is high.

Parameters:
NREGS, 32, number of registers; even, power of two.
DW, 64, register data width.
AW, 5, register address width; equals log2(NREGS).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start_save  input  1  one-cycle save request, sampled in IDLE only
start_restore  input  1  one-cycle restore request, sampled in IDLE only
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when an operation completes
rf_rdAddrA  output  AW  register file read address A
rf_rdAddrB  output  AW  register file read address B
rf_rdDataA  input  DW  register file read data A; combinational from rf_rdAddrA
rf_rdDataB  input  DW  register file read data B; combinational from rf_rdAddrB
rf_wrAddr  output  AW  register file write address, registered
rf_wrData  output  DW  register file write data, registered
rf_write  output  1  register file write enable, registered; the file writes on the clk edge
sv_data  output  DW  save stream data
sv_valid  output  1  save stream valid
sv_ready  input  1  save stream ready
rs_data  input  DW  restore stream data
rs_valid  input  1  restore stream valid
rs_ready  output  1  restore stream ready

Behaviour:
- Clock is clk. Reset is synchronous and active-high; it acts only on the rising edge of clk.
- Reset, including mid-operation, forces state IDLE and pair=0, idx=0.
- Reset values: busy=0, done=0, sv_valid=0, sv_data=0, rs_ready=0, rf_write=0, rf_wrAddr=0, rf_wrData=0, rf_rdAddrA=0, rf_rdAddrB=1.
- A reset mid-save drops the pending word without a handshake. A reset mid-restore deasserts rf_write on that same edge.
- rf_rdAddrA = {pair,1'b0} and rf_rdAddrB = {pair,1'b1} at all times. pair is an (AW-1)-bit counter.
- States: IDLE, SAVE_RD, SAVE_A, SAVE_B, RESTORE, DONE.
- IDLE:
  - start_save=1 -> SAVE_RD with pair=0.
  - Else start_restore=1 -> RESTORE with idx=0.
  - Both high: save wins and restore is dropped.
  - Starts are ignored in every other state.
- SAVE_RD (1 cycle): capture holdA<=rf_rdDataA and holdB<=rf_rdDataB, then -> SAVE_A.
- SAVE_A: sv_valid=1, sv_data=holdA. On sv_ready -> SAVE_B.
- SAVE_B: sv_valid=1, sv_data=holdB. On sv_ready:
  - If pair==NREGS/2-1 -> DONE.
  - Else pair<=pair+1 and -> SAVE_RD.
- Save stream rules:
  - sv_valid never drops and sv_data never changes until the handshake completes.
  - Stream order is reg0, reg1, ..., reg31.
  - sv_valid=0 and sv_data=0 outside SAVE_A and SAVE_B.
- RESTORE:
  - rs_ready=1 throughout the state.
  - On rs_valid&rs_ready, the next edge sets rf_wrData<=rs_data, rf_wrAddr<=idx, rf_write<=1, idx<=idx+1.
  - A cycle without a handshake sets rf_write<=0.
  - Accepting the word with idx==NREGS-1 -> DONE. rf_write is therefore high during the DONE cycle for the last write.
  - rs_ready=0 in all other states.
- DONE (1 cycle): done=1, busy=1, then -> IDLE. rf_write<=0 on exit. pair and idx are reset to 0.
- idx is an AW-bit counter. pair wraps to 0 only by leaving DONE, never by overflow.
- Latency:
  - Save with sv_ready held high: start sampled at edge 0; first sv_valid at cycle 2; 3 cycles per pair (48 total); done at cycle 49; busy low from cycle 50.
  - Restore with rs_valid held high: 32 consecutive rf_write cycles at cycles 2..33; done at cycle 33.
- Backpressure stalls only the state it occurs in; stalls have no timeout.

Test Plan:
- Reset check -> after reset, every output at its reset value, including rf_rdAddrB=1.
- Preload reg k with 64'h0101010101010101*k, pulse start_save, hold sv_ready=1 -> 32 beats in order reg0..reg31 with matching data; done at cycle 49 after the start edge.
- Save with sv_ready toggling 1,0,0,1 repeating -> no beat dropped or duplicated; sv_data stable whenever sv_valid=1 and sv_ready=0.
- Restore stream 64'hA5A5A5A5A5A5A5A5 ^ k for k=0..31, rs_valid gapped every third cycle -> rf_write pulses carry wrAddr=k and the matching data; a following save reads back identical values.
- start_save and start_restore asserted in the same cycle -> save runs. A second start_restore while busy -> ignored; no rf_write occurs.
- reset asserted during the 10th restore beat -> IDLE on that edge, rf_write=0, done never pulses. A fresh save shows regs 0..8 updated and 9..31 unchanged.

Source files
------------

// File: rtl/regfile_ctx_sequencer.sv
// Context save/restore sequencer for a 32x64 register file: dumps all registers as a
// ready/valid stream (save) or refills them from an incoming stream (restore).
module regfile_ctx_sequencer #(
    parameter int NREGS = 32,
    parameter int DW    = 64,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_save,
    input  logic          start_restore,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rf_rdAddrA,
    output logic [AW-1:0] rf_rdAddrB,
    input  logic [DW-1:0] rf_rdDataA,
    input  logic [DW-1:0] rf_rdDataB,
    output logic [AW-1:0] rf_wrAddr,
    output logic [DW-1:0] rf_wrData,
    output logic          rf_write,
    output logic [DW-1:0] sv_data,
    output logic          sv_valid,
    input  logic          sv_ready,
    input  logic [DW-1:0] rs_data,
    input  logic          rs_valid,
    output logic          rs_ready
);
    typedef enum logic [2:0] {IDLE, SAVE_RD, SAVE_A, SAVE_B, RESTORE, DONE} state_t;

    localparam logic [AW-2:0] PAIR_LAST = (AW-1)'(NREGS/2 - 1);
    localparam logic [AW-1:0] IDX_LAST  = AW'(NREGS - 1);

    state_t        state, state_nx;
    logic [AW-2:0] pair;
    logic [AW-1:0] idx;
    logic [DW-1:0] hold_a, hold_b;

    // Both read ports always point at the current even/odd register pair.
    assign rf_rdAddrA = {pair, 1'b0};
    assign rf_rdAddrB = {pair, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        sv_valid = 1'b0;
        sv_data  = '0;
        rs_ready = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_save)         state_nx = SAVE_RD;
                else if (start_restore) state_nx = RESTORE;
            end
            SAVE_RD: state_nx = SAVE_A;
            SAVE_A: begin
                sv_valid = 1'b1;
                sv_data  = hold_a;
                if (sv_ready) state_nx = SAVE_B;
            end
            SAVE_B: begin
                sv_valid = 1'b1;
                sv_data  = hold_b;
                if (sv_ready) state_nx = (pair == PAIR_LAST) ? DONE : SAVE_RD;
            end
            RESTORE: begin
                rs_ready = 1'b1;
                if (rs_valid && idx == IDX_LAST) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pair      <= '0;
            idx       <= '0;
            hold_a    <= '0;
            hold_b    <= '0;
            rf_write  <= 1'b0;
            rf_wrAddr <= '0;
            rf_wrData <= '0;
        end else begin
            // Write strobe is only ever high for the cycle after an accepted restore word.
            rf_write <= 1'b0;
            case (state)
                IDLE: begin
                    pair <= '0;
                    idx  <= '0;
                end
                SAVE_RD: begin
                    hold_a <= rf_rdDataA;
                    hold_b <= rf_rdDataB;
                end
                SAVE_B: begin
                    if (sv_ready && pair != PAIR_LAST) pair <= pair + (AW-1)'(1);
                end
                RESTORE: begin
                    if (rs_valid) begin
                        rf_wrData <= rs_data;
                        rf_wrAddr <= idx;
                        rf_write  <= 1'b1;
                        idx       <= idx + AW'(1);
                    end
                end
                DONE: begin
                    pair <= '0;
                    idx  <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
